// File: rtl/hline_mem_responder.sv
// hline_mem_responder: on-chip word array that answers the hline z-buffer engine's
// read/write bursts (1..256 words) with per-byte write enables.
// Ports: clk/nreset (sync, active-low); rd_req/wr_req/addr/burst_len request with
// req_ack/err/busy status; wr_data/byteenable/wr_valid/wr_ready write beats;
// rd_data/rd_valid/rd_ready read beats. Memory contents survive reset.
module hline_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          AW        = 10
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [8:0]  burst_len,
  output logic        req_ack,
  output logic        err,
  output logic        busy,
  input  logic [31:0] wr_data,
  input  logic [3:0]  byteenable,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] idx;
  logic [8:0]    remaining;   // beats not yet fetched (READ) or written (WRITE)
  logic [31:0]   mem [DEPTH];

  // Request decode. The end index is formed 33 bits wide so a huge offset
  // plus burst_len cannot wrap back into the window.
  logic [31:0] offset;
  logic [32:0] req_word;
  logic [32:0] req_end;
  logic        req_legal;
  logic        wr_beat;
  logic        rd_fetch;
  logic        rd_done;

  always_comb begin
    offset    = addr - BASE_ADDR;
    req_word  = {1'b0, offset} >> 2;
    req_end   = req_word + {24'b0, burst_len};
    req_legal = (addr >= BASE_ADDR) && (burst_len != 9'd0) &&
                (burst_len <= 9'd256) && (req_end <= 33'(DEPTH));
  end

  assign busy     = (state != S_IDLE);
  assign wr_beat  = (state == S_WRITE) && wr_valid;
  // Output register is free when empty or being drained this cycle.
  assign rd_fetch = (state == S_READ) && (!rd_valid || rd_ready) && (remaining != 9'd0);
  assign rd_done  = (state == S_READ) && rd_valid && rd_ready && (remaining == 9'd0);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= S_IDLE;
      idx       <= '0;
      remaining <= '0;
      req_ack   <= 1'b0;
      err       <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      req_ack <= 1'b0;
      err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_req || wr_req) begin
            if (req_legal && !(rd_req && wr_req)) begin
              req_ack   <= 1'b1;
              idx       <= req_word[AW-1:0];
              remaining <= burst_len;
              if (rd_req) begin
                state <= S_READ;
              end else begin
                state    <= S_WRITE;
                wr_ready <= 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (rd_fetch) begin
            rd_data   <= mem[idx];
            rd_valid  <= 1'b1;
            idx       <= idx + 1'b1;
            remaining <= remaining - 1'b1;
          end else if (rd_done) begin
            rd_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (wr_beat) begin
            idx       <= idx + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == 9'd1) begin
              state    <= S_IDLE;
              wr_ready <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage has no reset; a beat presented while nreset is low is dropped.
  always_ff @(posedge clk) begin
    if (nreset && wr_beat) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_hline_mem_responder.sv
module tb_hline_mem_responder;

  logic        clk = 1'b0;
  logic        nreset;
  logic        rd_req, wr_req;
  logic [31:0] addr;
  logic [8:0]  burst_len;
  logic        req_ack, err, busy;
  logic [31:0] wr_data;
  logic [3:0]  byteenable;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model [1024];
  logic [31:0] wbuf  [256];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  hline_mem_responder dut (
    .clk(clk), .nreset(nreset),
    .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .burst_len(burst_len),
    .req_ack(req_ack), .err(err), .busy(busy),
    .wr_data(wr_data), .byteenable(byteenable), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1ns after a rising edge.
  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [8:0] len, input logic ok);
    rd_req = r; wr_req = w; addr = a; burst_len = len;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    check_val("req_ack", {31'b0, req_ack}, {31'b0, ok});
    check_val("err",     {31'b0, err},     {31'b0, !ok});
    check_val("busy",    {31'b0, busy},    {31'b0, ok});
  endtask

  task automatic wr_burst(input logic [31:0] a, input int len, input logic [3:0] be);
    int base;
    base = int'(a >> 2);
    issue(1'b0, 1'b1, a, 9'(len), 1'b1);
    check_val("wr_ready_on", {31'b0, wr_ready}, 32'd1);
    for (int i = 0; i < len; i++) begin
      wr_valid = 1'b1; wr_data = wbuf[i]; byteenable = be;
      @(posedge clk); #1;
      for (int b = 0; b < 4; b++)
        if (be[b]) model[base+i][8*b +: 8] = wbuf[i][8*b +: 8];
    end
    wr_valid = 1'b0;
    check_val("wr_ready_off", {31'b0, wr_ready}, 32'd0);
    check_val("wr_idle",      {31'b0, busy},     32'd0);
  endtask

  task automatic rd_burst(input logic [31:0] a, input int len, input bit toggle);
    int base, n, cyc;
    base = int'(a >> 2); n = 0; cyc = 0;
    issue(1'b1, 1'b0, a, 9'(len), 1'b1);
    check_val("rd_valid_ack_cycle", {31'b0, rd_valid}, 32'd0);
    while (n < len && cyc < 2000) begin
      rd_ready = toggle ? ~cyc[0] : 1'b1;
      @(negedge clk);
      if (rd_valid) begin
        check_val(rd_ready ? "rd_beat" : "rd_stall_hold", rd_data, model[base+n]);
        if (rd_ready) begin
          last_rd = rd_data;
          n++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd_ready = 1'b0;
    check_val("rd_beats", n, len);
    if (!toggle) check_val("rd_cycles", cyc, len + 1);
    check_val("rd_valid_end", {31'b0, rd_valid}, 32'd0);
    check_val("rd_idle",      {31'b0, busy},     32'd0);
  endtask

  initial begin
    nreset = 1'b0; rd_req = 1'b0; wr_req = 1'b0; addr = '0; burst_len = '0;
    wr_data = '0; byteenable = '0; wr_valid = 1'b0; rd_ready = 1'b0; last_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req_ack",  {31'b0, req_ack},  32'd0);
    check_val("rst_err",      {31'b0, err},      32'd0);
    check_val("rst_busy",     {31'b0, busy},     32'd0);
    check_val("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    check_val("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    check_val("rst_rd_data",  rd_data,           32'd0);
    nreset = 1'b1;
    @(posedge clk); #1;

    // 1: write/read 4 words at byte 0x10
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    wr_burst(32'h10, 4, 4'hF);
    rd_burst(32'h10, 4, 1'b0);
    check_val("t1_last", last_rd, 32'h44);

    // 2: byte-enable merge
    wbuf[0] = 32'hAABBCCDD;
    wr_burst(32'h0, 1, 4'hF);
    wbuf[0] = 32'h11223344;
    wr_burst(32'h0, 1, 4'b0101);
    rd_burst(32'h0, 1, 1'b0);
    check_val("t2_merge", last_rd, 32'hAA22CC44);

    // 3: 256-beat read with rd_ready toggling
    for (int i = 0; i < 256; i++) wbuf[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
    wr_burst(32'h400, 256, 4'hF);
    rd_burst(32'h400, 256, 1'b1);
    check_val("t3_last", last_rd, 32'h5A00_0000 ^ (255 * 32'h0001_0203));

    // 4: window edge accepted, then illegal requests rejected
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hE000_0000 + i;
    wr_burst(1020 * 4, 4, 4'hF);
    rd_burst(1020 * 4, 4, 1'b0);
    check_val("t4_edge_last", last_rd, 32'hE000_0003);
    issue(1'b1, 1'b0, 1022 * 4, 9'd4, 1'b0);
    @(posedge clk); #1;
    check_val("err_pulse_once", {31'b0, err}, 32'd0);
    issue(1'b0, 1'b1, 32'h10, 9'd0, 1'b0);
    wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF; byteenable = 4'hF;   // must be ignored
    @(posedge clk); #1;
    wr_valid = 1'b0;
    issue(1'b0, 1'b1, 32'h10, 9'd257, 1'b0);
    issue(1'b1, 1'b1, 32'h10, 9'd4, 1'b0);
    check_val("t4_wr_ready", {31'b0, wr_ready}, 32'd0);
    rd_burst(32'h10, 4, 1'b0);
    check_val("t4_unchanged", last_rd, 32'h44);

    // 5: reset in the middle of a write burst
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h0D0D_0000 + i;
    wr_burst(32'h100, 8, 4'hF);
    issue(1'b0, 1'b1, 32'h100, 9'd8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 32'hCAFE_0000 + i; byteenable = 4'hF;
      @(posedge clk); #1;
      model[64+i] = 32'hCAFE_0000 + i;
    end
    wr_valid = 1'b0;
    nreset = 1'b0;
    @(posedge clk); #1;
    check_val("t5_busy",     {31'b0, busy},     32'd0);
    check_val("t5_wr_ready", {31'b0, wr_ready}, 32'd0);
    check_val("t5_req_ack",  {31'b0, req_ack},  32'd0);
    check_val("t5_rd_data",  rd_data,           32'd0);
    nreset = 1'b1;
    @(posedge clk); #1;
    rd_burst(32'h100, 8, 1'b0);
    check_val("t5_word7_old", last_rd, 32'h0D0D_0007);

    // 6: back-to-back single-word reads
    rd_burst(32'h14, 1, 1'b0);
    check_val("t6_first", last_rd, 32'h22);
    rd_burst(32'h0, 1, 1'b0);
    check_val("t6_second", last_rd, 32'hAA22CC44);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
